// File: rtl/nn_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : nn_config_sequencer
// Description : Loads a byte-serial network descriptor, commits it to the
//               inference core, fires start and supervises the run.
// Revision    : 1.0 - initial release
// ============================================================================
module nn_config_sequencer #(
    parameter int MAX_LAYERS  = 5,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_data,
    input  logic       cfg_last,
    input  logic       nn_done,
    output logic       start,
    output logic [5:0] no_layers,
    output logic [5:0] nl1,
    output logic [5:0] nl2,
    output logic [5:0] nl3,
    output logic [5:0] nl4,
    output logic [5:0] nl5,
    output logic [1:0] afl1,
    output logic [1:0] afl2,
    output logic [1:0] afl3,
    output logic [1:0] afl4,
    output logic [1:0] afl5,
    output logic       busy,
    output logic       run_done,
    output logic       err,
    output logic [2:0] err_code
);

    localparam int c_NPORT = 5;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_LOAD  = 3'd1;
    localparam logic [2:0] c_S_DRAIN = 3'd2;
    localparam logic [2:0] c_S_FIRE  = 3'd3;
    localparam logic [2:0] c_S_RUN   = 3'd4;

    localparam logic [2:0] c_E_NONE    = 3'd0;
    localparam logic [2:0] c_E_COUNT   = 3'd1;
    localparam logic [2:0] c_E_ZERO    = 3'd2;
    localparam logic [2:0] c_E_FRAME   = 3'd3;
    localparam logic [2:0] c_E_TIMEOUT = 3'd4;

    logic [2:0] r_state;
    logic [2:0] w_state_next;

    logic       w_accept;
    logic       w_hdr;
    logic       w_hdr_bad;
    logic [5:0] w_byte_nl;
    logic [1:0] w_byte_afl;
    logic       w_err_set;
    logic [2:0] w_err_code_new;
    logic       w_fire_go;
    logic       w_run_ok;
    logic       w_wd_hit;

    logic [5:0] r_sh_layers;
    logic [5:0] r_idx;
    logic [5:0] r_sh_nl  [1:c_NPORT];
    logic [1:0] r_sh_afl [1:c_NPORT];

    logic [5:0] r_layers;
    logic [5:0] r_nl     [1:c_NPORT];
    logic [1:0] r_afl    [1:c_NPORT];
    logic       r_run_done;
    logic       r_err;
    logic [2:0] r_err_code;

    assign w_accept   = cfg_valid & cfg_ready;
    assign w_hdr      = w_accept && (r_state == c_S_IDLE);
    assign w_byte_nl  = cfg_data[5:0];
    assign w_byte_afl = cfg_data[7:6];
    assign w_hdr_bad  = (w_byte_nl == 6'd0) || (w_byte_nl > 6'(MAX_LAYERS));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and error-event logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next   = r_state;
        w_err_set      = 1'b0;
        w_err_code_new = c_E_NONE;
        w_fire_go      = 1'b0;
        w_run_ok       = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    if (w_hdr_bad) begin
                        w_err_set      = 1'b1;
                        w_err_code_new = c_E_COUNT;
                        w_state_next   = cfg_last ? c_S_IDLE : c_S_DRAIN;
                    end else if (cfg_last) begin
                        w_err_set      = 1'b1;
                        w_err_code_new = c_E_FRAME;
                        w_state_next   = c_S_IDLE;
                    end else begin
                        w_state_next   = c_S_LOAD;
                    end
                end
            end
            c_S_LOAD: begin
                if (w_accept) begin
                    if (w_byte_nl == 6'd0) begin
                        w_err_set      = 1'b1;
                        w_err_code_new = c_E_ZERO;
                        w_state_next   = cfg_last ? c_S_IDLE : c_S_DRAIN;
                    end else if (cfg_last && (r_idx < r_sh_layers)) begin
                        w_err_set      = 1'b1;
                        w_err_code_new = c_E_FRAME;
                        w_state_next   = c_S_IDLE;
                    end else if ((r_idx == r_sh_layers) && !cfg_last) begin
                        w_err_set      = 1'b1;
                        w_err_code_new = c_E_FRAME;
                        w_state_next   = c_S_DRAIN;
                    end else if (r_idx == r_sh_layers) begin
                        w_fire_go      = 1'b1;
                        w_state_next   = c_S_FIRE;
                    end
                end
            end
            c_S_DRAIN: begin
                if (w_accept && cfg_last) begin
                    w_state_next = c_S_IDLE;
                end
            end
            c_S_FIRE: begin
                w_state_next = c_S_RUN;
            end
            c_S_RUN: begin
                // Completion beats a watchdog expiry landing on the same cycle.
                if (nn_done) begin
                    w_run_ok     = 1'b1;
                    w_state_next = c_S_IDLE;
                end else if (w_wd_hit) begin
                    w_err_set      = 1'b1;
                    w_err_code_new = c_E_TIMEOUT;
                    w_state_next   = c_S_IDLE;
                end
            end
            default: begin
                w_state_next = c_S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        cfg_ready = 1'b0;
        start     = 1'b0;
        busy      = 1'b0;
        case (r_state)
            c_S_IDLE, c_S_LOAD, c_S_DRAIN: cfg_ready = rst_n;
            c_S_FIRE: begin
                start = 1'b1;
                busy  = 1'b1;
            end
            c_S_RUN:  busy = 1'b1;
            default:  cfg_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow descriptor capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_layers <= 6'd0;
            r_idx       <= 6'd0;
            for (int i = 1; i <= c_NPORT; i++) begin
                r_sh_nl[i]  <= 6'd0;
                r_sh_afl[i] <= 2'd0;
            end
        end else if (w_hdr && (w_state_next == c_S_LOAD)) begin
            r_sh_layers <= w_byte_nl;
            r_idx       <= 6'd1;
            for (int i = 1; i <= c_NPORT; i++) begin
                r_sh_nl[i]  <= 6'd0;
                r_sh_afl[i] <= 2'd0;
            end
        end else if (w_accept && (r_state == c_S_LOAD)) begin
            r_idx <= r_idx + 6'd1;
            for (int i = 1; i <= c_NPORT; i++) begin
                if (r_idx == 6'(i)) begin
                    r_sh_nl[i]  <= w_byte_nl;
                    r_sh_afl[i] <= w_byte_afl;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Committed configuration: loaded on entry to FIRE (merging the final
    // byte) so the core sees a stable config in the same cycle as start.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layers <= 6'd0;
            for (int i = 1; i <= c_NPORT; i++) begin
                r_nl[i]  <= 6'd0;
                r_afl[i] <= 2'd0;
            end
        end else if (w_fire_go) begin
            r_layers <= r_sh_layers;
            for (int i = 1; i <= c_NPORT; i++) begin
                r_nl[i]  <= (r_idx == 6'(i)) ? w_byte_nl  : r_sh_nl[i];
                r_afl[i] <= (r_idx == 6'(i)) ? w_byte_afl : r_sh_afl[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Status: run_done pulse and sticky first-error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_done <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= c_E_NONE;
        end else begin
            r_run_done <= w_run_ok;
            if (w_hdr) begin
                r_err      <= w_err_set;
                r_err_code <= w_err_code_new;
            end else if (w_err_set && !r_err) begin
                r_err      <= 1'b1;
                r_err_code <= w_err_code_new;
            end
        end
    end

    // ------------------------------------------------------------------
    // Watchdog: r_wd counts cycles since the start cycle, saturating.
    // ------------------------------------------------------------------
    generate
        if (TIMEOUT_CYC == 0) begin : g_wd_off
            assign w_wd_hit = 1'b0;
        end else begin : g_wd_on
            localparam int c_WD_W = $clog2(TIMEOUT_CYC + 1);
            localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT_CYC);
            logic [c_WD_W-1:0] r_wd;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wd <= '0;
                end else if (w_fire_go) begin
                    r_wd <= '0;
                end else if (((r_state == c_S_FIRE) || (r_state == c_S_RUN)) &&
                             (r_wd != c_WD_MAX)) begin
                    r_wd <= r_wd + c_WD_W'(1);
                end
            end

            assign w_wd_hit = (r_wd >= (c_WD_MAX - c_WD_W'(1)));
        end
    endgenerate

    assign no_layers = r_layers;
    assign nl1       = r_nl[1];
    assign nl2       = r_nl[2];
    assign nl3       = r_nl[3];
    assign nl4       = r_nl[4];
    assign nl5       = r_nl[5];
    assign afl1      = r_afl[1];
    assign afl2      = r_afl[2];
    assign afl3      = r_afl[3];
    assign afl4      = r_afl[4];
    assign afl5      = r_afl[5];
    assign run_done  = r_run_done;
    assign err       = r_err;
    assign err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_nn_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_nn_config_sequencer
// Description : Directed and random descriptor streams checked against a
//               frame-level reference model of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nn_config_sequencer;

    localparam int c_T  = 24;
    localparam int c_ML = 5;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [7:0] cfg_data = 8'h00;
    logic       cfg_last = 1'b0;
    logic       nn_done = 1'b0;
    logic       start;
    logic [5:0] no_layers, nl1, nl2, nl3, nl4, nl5;
    logic [1:0] afl1, afl2, afl3, afl4, afl5;
    logic       busy, run_done, err;
    logic [2:0] err_code;

    logic [45:0] dut_cfg;
    logic [45:0] exp_cfg = '0;
    int total = 0;
    int bad   = 0;

    assign dut_cfg = {no_layers, nl1, nl2, nl3, nl4, nl5, afl1, afl2, afl3, afl4, afl5};

    nn_config_sequencer #(.MAX_LAYERS(c_ML), .TIMEOUT_CYC(c_T)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_last(cfg_last), .nn_done(nn_done), .start(start),
        .no_layers(no_layers), .nl1(nl1), .nl2(nl2), .nl3(nl3), .nl4(nl4), .nl5(nl5),
        .afl1(afl1), .afl2(afl2), .afl3(afl3), .afl4(afl4), .afl5(afl5),
        .busy(busy), .run_done(run_done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame-level outcome: error code (0 = fires) and the config it would commit.
    function automatic void eval_frame(input bq_t q, output int code, output logic [45:0] cfg);
        logic [5:0] lc;
        logic [5:0] nls [1:5];
        logic [1:0] afs [1:5];
        int n;
        for (int i = 1; i <= 5; i++) begin
            nls[i] = 6'd0;
            afs[i] = 2'd0;
        end
        code = 0;
        n    = q.size();
        lc   = q[0][5:0];
        if (lc == 6'd0 || int'(lc) > c_ML) begin
            code = 1;
        end else if (n == 1) begin
            code = 3;
        end else begin
            for (int k = 1; k < n; k++) begin
                if (q[k][5:0] == 6'd0) begin
                    code = 2;
                    break;
                end
                nls[k] = q[k][5:0];
                afs[k] = q[k][7:6];
                if ((k == n - 1) && (k < int'(lc))) begin
                    code = 3;
                    break;
                end
                if (k == int'(lc)) begin
                    if (k != n - 1) code = 3;
                    break;
                end
            end
        end
        cfg = {lc, nls[1], nls[2], nls[3], nls[4], nls[5],
               afs[1], afs[2], afs[3], afs[4], afs[5]};
    endfunction

    task automatic send_frame(input bq_t q);
        for (int i = 0; i < q.size(); i++) begin
            cfg_valid = 1'b1;
            cfg_data  = q[i];
            cfg_last  = (i == q.size() - 1);
            check("ready", 64'(cfg_ready), 64'd1);
            step();
            if (i == 0 && q.size() > 1)
                check("hdr_err", 64'(err), 64'(q[0][5:0] == 6'd0 || int'(q[0][5:0]) > c_ML));
        end
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check(tag, {cfg_ready, start, busy, run_done, err, err_code, dut_cfg}, 64'd0);
    endtask

    // dly >= 0: nn_done after dly RUN cycles; -1: withhold (timeout); -2: reset mid-RUN.
    task automatic run_frame(input bq_t q, input int dly);
        int code;
        logic [45:0] cfg;
        eval_frame(q, code, cfg);
        send_frame(q);
        if (code != 0) begin
            check("err", 64'(err), 64'd1);
            check("err_code", 64'(err_code), 64'(code));
            check("idle_flags", {start, busy, cfg_ready}, 64'b001);
            check("cfg_hold_err", 64'(dut_cfg), 64'(exp_cfg));
            return;
        end
        exp_cfg = cfg;
        check("start", 64'(start), 64'd1);
        check("fire_flags", {busy, cfg_ready, err}, 64'b100);
        check("cfg_commit", 64'(dut_cfg), 64'(exp_cfg));
        nn_done   = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'($urandom);
        cfg_last  = 1'($urandom_range(0, 1));
        step();
        nn_done = 1'b0;
        check("start_pulse", {start, busy, cfg_ready}, 64'b010);
        if (dly == -2) begin
            repeat (3) step();
            #2 rst_n = 1'b0;
            #1;
            check_zero("rst_run");
            exp_cfg   = '0;
            cfg_valid = 1'b0;
            cfg_last  = 1'b0;
            step();
            rst_n = 1'b1;
            step();
            return;
        end
        if (dly < 0) begin
            repeat (c_T - 2) step();
            check("wd_pre", {err, busy}, 64'b01);
            cfg_valid = 1'b0;
            cfg_last  = 1'b0;
            step();
            check("wd_err", {err, err_code, busy, run_done}, {58'd0, 1'b1, 3'd4, 1'b0, 1'b0});
            check("cfg_hold_wd", 64'(dut_cfg), 64'(exp_cfg));
            return;
        end
        repeat (dly) step();
        nn_done   = 1'b1;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        step();
        nn_done = 1'b0;
        check("run_done", {run_done, busy, err}, 64'b100);
        check("cfg_hold_run", 64'(dut_cfg), 64'(exp_cfg));
        step();
        check("run_done_pulse", 64'(run_done), 64'd0);
    endtask

    task automatic rand_frame(output bq_t q);
        int lc, n;
        logic [7:0] b;
        lc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 5));
        if ($urandom_range(0, 3) != 0 && lc >= 1 && lc <= c_ML) n = lc + 1;
        else n = int'($urandom_range(1, 7));
        q = {};
        q.push_back({2'($urandom), 6'(lc)});
        for (int i = 1; i < n; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 11) == 0) b[5:0] = 6'd0;
            else if (b[5:0] == 6'd0) b[5:0] = 6'h2A;
            q.push_back(b);
        end
    endtask

    initial begin
        bq_t q;
        #2;
        check_zero("reset_state");
        step();
        rst_n = 1'b1;
        step();

        q = '{8'h02, 8'h02, 8'h01};             run_frame(q, 3);
        q = '{8'h00};                            run_frame(q, 0);
        q = '{8'h06, 8'h11, 8'h22, 8'h33};       run_frame(q, 0);
        q = '{8'h03, 8'hC5, 8'h00, 8'h02};       run_frame(q, 0);
        q = '{8'h01, 8'h41};                     run_frame(q, 0);
        q = '{8'h03, 8'h04, 8'h04};              run_frame(q, 0);
        q = '{8'h01, 8'h04, 8'h04};              run_frame(q, 0);
        q = '{8'hC1, 8'h83};                     run_frame(q, -1);
        q = '{8'h01, 8'h02};                     run_frame(q, c_T - 2);
        q = '{8'h05, 8'h3F, 8'h81, 8'h42, 8'hC7, 8'h10}; run_frame(q, 1);

        // nn_done while idle must not produce completion.
        nn_done = 1'b1;
        repeat (3) step();
        check("done_idle", {run_done, busy}, 64'b00);
        nn_done = 1'b0;
        step();

        // Asynchronous reset in the middle of a load.
        cfg_valid = 1'b1; cfg_data = 8'h03; cfg_last = 1'b0;
        step();
        cfg_data = 8'h05;
        step();
        #2 rst_n = 1'b0;
        #1;
        check_zero("rst_load");
        exp_cfg   = '0;
        cfg_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();

        q = '{8'h02, 8'h15, 8'hE9};              run_frame(q, 2);
        q = '{8'h02, 8'h3F, 8'hFF};              run_frame(q, -2);
        q = '{8'h04, 8'h01, 8'h02, 8'h03, 8'h44}; run_frame(q, 5);

        for (int r = 0; r < 40; r++) begin
            rand_frame(q);
            run_frame(q, ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, c_T - 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
